fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Pointer and status controller for the UART RX/TX FIFOs. Generates the write/read addresses and the write enable for the companion register-file storage, and tracks full/empty/occupancy. Sits beside the register file inside the FIFO wrapper: the UART receiver or host bus drives `wr`, and the transmitter or host bus drives `rd`. Reads are first-word-fall-through: the head entry is visible on the storage read port whenever `empty` is 0, and `rd` pops it.

## Interface
- `ADDR_WIDTH`, default 2: address bits; depth = 2**ADDR_WIDTH.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `wr` in 1: push request; data is presented to storage `w_data` by the producer.
- `rd` in 1: pop request; consumes the entry currently at `r_addr`.
- `wr_en` out 1: combinational write strobe to storage; equals `wr & (~full | rd)`.
- `w_addr` out ADDR_WIDTH: registered write pointer.
- `r_addr` out ADDR_WIDTH: registered read pointer (head).
- `empty` out 1: registered; no valid entries.
- `full` out 1: registered; depth entries held.
- `count` out ADDR_WIDTH+1: registered occupancy, 0..2**ADDR_WIDTH.
- `overflow` out 1: registered one-cycle pulse on a rejected push.
- `underflow` out 1: registered one-cycle pulse on a rejected pop.

## Operation
- Reset values: `w_addr`=0, `r_addr`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `underflow`=0.
- Pointers increment modulo 2**ADDR_WIDTH and wrap from max to 0 without any special case.
- Per-cycle operation decoded from {wr, rd}:
  - NOP: no change.
  - WR only, not full: `w_addr`+1, `count`+1, `empty`<=0, `full`<=(`w_addr`+1 == `r_addr`).
  - WR only, full: no change; `overflow` pulses.
  - RD only, not empty: `r_addr`+1, `count`-1, `full`<=0, `empty`<=(`r_addr`+1 == `w_addr`).
  - RD only, empty: no change; `underflow` pulses.
  - WR+RD, neither flag set: both pointers advance; `count`, `empty`, and `full` are unchanged.
  - WR+RD, empty: the write is accepted and the pop is rejected. `w_addr`+1, `count`+1, `empty`<=0, and `underflow` pulses.
  - WR+RD, full: both are accepted and both pointers advance. `full` stays 1 and `count` is unchanged. The head is consumed in the same cycle its slot is rewritten, which is legal because storage read is combinational.
- `overflow`/`underflow` are 0 in every cycle without a rejected request.
- Invariants: `empty` == (`count`==0) and `full` == (`count`==2**ADDR_WIDTH), every cycle.

## Timing
- All state updates on the rising edge of `clk`; `reset` has priority over `wr`/`rd`.
- `wr_en` is combinational from `wr`, `rd`, and `full`; storage captures data at the same edge the pointer advances.
- Write at edge N: `empty` falls after N, and the data appears on storage `r_data` in cycle N+1.
- Pop at edge N: the next entry is visible in cycle N+1.
- Error pulses are asserted in the cycle after the offending request and last exactly one cycle.
- `reset` asserted mid-stream discards all contents at that edge; requests in the reset cycle are ignored.

## Structure
- Shared package `uart_pkg`:
  - typedef enum `fifo_op_t` {`FIFO_NOP`, `FIFO_RD`, `FIFO_WR`, `FIFO_RDWR`} used for the {wr, rd} decode.
  - Default `FIFO_ADDR_WIDTH` constant.
- Logic: one `always_ff` for pointers, flags, count, and error pulses, plus `always_comb` next-state logic.
- No sub-module. `fifo_ctrl` and the register file are instantiated side by side in the FIFO wrapper `uart_fifo`.

## Test plan
- Reset, then idle 3 cycles: `empty`=1, `full`=0, `count`=0, both addresses 0, no error pulses.
- 4 single pushes (ADDR_WIDTH=2): `w_addr` steps 1,2,3,0; `full`=1 after the 4th; `count`=4. A 5th push gives `wr_en`=0, an `overflow` pulse, and no state change.
- From full, 4 pops: `r_addr` steps 1,2,3,0; `empty`=1 after the 4th. A 5th pop gives an `underflow` pulse.
- WR+RD when empty: `count` 0->1, `w_addr`+1, `r_addr` held, `underflow` pulses.
- WR+RD when full: both pointers +1, `full` stays 1, `count`=4, `wr_en`=1.
- Fill 2 entries, assert `reset` together with `wr`: next cycle all outputs are at reset values and `count`=0.
- Run 20 cycles of random wr/rd across wrap-around: `count` matches a scoreboard and the `empty`/`full` invariants hold every cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and defaults for the UART FIFO blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Encoding matches the {wr, rd} concatenation.
  typedef enum logic [1:0] {
    FIFO_NOP  = 2'b00,
    FIFO_RD   = 2'b01,
    FIFO_WR   = 2'b10,
    FIFO_RDWR = 2'b11
  } fifo_op_t;

  localparam int FIFO_ADDR_WIDTH = 2;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// ============================================================================
// Module      : fifo_ctrl
// Description : Pointer/status controller for a first-word-fall-through FIFO
//               built around a companion register-file storage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_ctrl
  import uart_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH-1:0] c_addr_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   c_count_one = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] r_w_addr, r_r_addr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_empty, r_full, r_overflow, r_underflow;

  logic [ADDR_WIDTH-1:0] w_w_addr_nxt, w_r_addr_nxt;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic                  w_empty_nxt, w_full_nxt, w_overflow_nxt, w_underflow_nxt;
  logic [ADDR_WIDTH-1:0] w_w_addr_inc, w_r_addr_inc;
  fifo_op_t              w_op;

  assign w_op         = fifo_op_t'({wr, rd});
  assign w_w_addr_inc = r_w_addr + c_addr_one;
  assign w_r_addr_inc = r_r_addr + c_addr_one;

  // A push into a full FIFO is still accepted when a pop frees the head slot.
  assign wr_en = wr & (~r_full | rd);

  always_comb begin
    w_w_addr_nxt    = r_w_addr;
    w_r_addr_nxt    = r_r_addr;
    w_count_nxt     = r_count;
    w_empty_nxt     = r_empty;
    w_full_nxt      = r_full;
    w_overflow_nxt  = 1'b0;
    w_underflow_nxt = 1'b0;
    case (w_op)
      FIFO_WR: begin
        if (r_full) begin
          w_overflow_nxt = 1'b1;
        end else begin
          w_w_addr_nxt = w_w_addr_inc;
          w_count_nxt  = r_count + c_count_one;
          w_empty_nxt  = 1'b0;
          w_full_nxt   = (w_w_addr_inc == r_r_addr);
        end
      end
      FIFO_RD: begin
        if (r_empty) begin
          w_underflow_nxt = 1'b1;
        end else begin
          w_r_addr_nxt = w_r_addr_inc;
          w_count_nxt  = r_count - c_count_one;
          w_full_nxt   = 1'b0;
          w_empty_nxt  = (w_r_addr_inc == r_w_addr);
        end
      end
      FIFO_RDWR: begin
        if (r_empty) begin
          // Nothing to pop yet: the write lands, the pop is rejected.
          w_w_addr_nxt    = w_w_addr_inc;
          w_count_nxt     = r_count + c_count_one;
          w_empty_nxt     = 1'b0;
          w_full_nxt      = (w_w_addr_inc == r_r_addr);
          w_underflow_nxt = 1'b1;
        end else begin
          w_w_addr_nxt = w_w_addr_inc;
          w_r_addr_nxt = w_r_addr_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_w_addr    <= '0;
      r_r_addr    <= '0;
      r_count     <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_w_addr    <= w_w_addr_nxt;
      r_r_addr    <= w_r_addr_nxt;
      r_count     <= w_count_nxt;
      r_empty     <= w_empty_nxt;
      r_full      <= w_full_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  assign w_addr    = r_w_addr;
  assign r_addr    = r_r_addr;
  assign count     = r_count;
  assign empty     = r_empty;
  assign full      = r_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule : fifo_ctrl

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
// ============================================================================
// Module      : tb_fifo_ctrl
// Description : Directed and short random self-checking bench for fifo_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_ctrl;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset, wr, rd;
  logic          wr_en, empty, full, overflow, underflow;
  logic [AW-1:0] w_addr, r_addr;
  logic [AW:0]   count;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_w, m_r, m_cnt;
  bit m_ovf, m_udf;

  fifo_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wr(wr), .rd(rd), .wr_en(wr_en),
    .w_addr(w_addr), .r_addr(r_addr), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_w = 0; m_r = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, " w_addr"},    32'(w_addr),    32'(m_w));
    chk({tag, " r_addr"},    32'(r_addr),    32'(m_r));
    chk({tag, " count"},     32'(count),     32'(m_cnt));
    chk({tag, " empty"},     32'(empty),     32'(m_cnt == 0));
    chk({tag, " full"},      32'(full),      32'(m_cnt == DEPTH));
    chk({tag, " overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(m_udf));
  endtask

  // Apply one request cycle, then compare every output with the model.
  task automatic cycle(input logic w, input logic r, input string tag);
    bit acc_w, acc_r;
    wr = w; rd = r;
    #1;
    acc_w = w && ((m_cnt != DEPTH) || r);
    acc_r = r && (m_cnt != 0);
    chk({tag, " wr_en"}, 32'(wr_en), 32'(acc_w));
    @(posedge clk); #1;
    m_ovf = w && !acc_w;
    m_udf = r && !acc_r;
    if (acc_w) m_w = (m_w + 1) % DEPTH;
    if (acc_r) m_r = (m_r + 1) % DEPTH;
    m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
    chk_state(tag);
    wr = 1'b0; rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr = 1'b0; rd = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    chk_state("reset");

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "idle");

    // Fill to full, then one rejected push
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, "push");
      chk("push w_addr step", 32'(w_addr), 32'((i + 1) % 4));
    end
    chk("filled full", 32'(full), 32'd1);
    chk("filled count", 32'(count), 32'd4);
    cycle(1'b1, 1'b0, "push5");
    chk("push5 overflow", 32'(overflow), 32'd1);
    chk("push5 w_addr", 32'(w_addr), 32'd0);
    cycle(1'b0, 1'b0, "after_ovf");

    // Drain, then one rejected pop
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, "pop");
      chk("pop r_addr step", 32'(r_addr), 32'((i + 1) % 4));
    end
    chk("drained empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b1, "pop5");
    chk("pop5 underflow", 32'(underflow), 32'd1);
    cycle(1'b0, 1'b0, "after_udf");

    // Simultaneous push/pop on an empty FIFO
    cycle(1'b1, 1'b1, "rdwr_empty");
    chk("rdwr_empty count", 32'(count), 32'd1);
    chk("rdwr_empty w_addr", 32'(w_addr), 32'd1);
    chk("rdwr_empty r_addr", 32'(r_addr), 32'd0);
    chk("rdwr_empty underflow", 32'(underflow), 32'd1);

    // Simultaneous push/pop on a full FIFO
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "refill");
    chk("refill full", 32'(full), 32'd1);
    wr = 1'b1; rd = 1'b1; #1;
    chk("rdwr_full wr_en", 32'(wr_en), 32'd1);
    cycle(1'b1, 1'b1, "rdwr_full");
    chk("rdwr_full w_addr", 32'(w_addr), 32'd1);
    chk("rdwr_full r_addr", 32'(r_addr), 32'd1);
    chk("rdwr_full full", 32'(full), 32'd1);
    chk("rdwr_full count", 32'(count), 32'd4);
    chk("rdwr_full overflow", 32'(overflow), 32'd0);

    // Mid-stream reset together with a push
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, "drain");
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, "part");
    chk("part count", 32'(count), 32'd2);
    reset = 1'b1; wr = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; wr = 1'b0;
    model_reset();
    chk("rst count", 32'(count), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst w_addr", 32'(w_addr), 32'd0);
    chk_state("mid_reset");

    // Random traffic across wrap-around
    for (int i = 0; i < 20; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fifo_ctrl

`default_nettype wire
